// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver
//   Time-multiplexed seven-segment display driver. It scans N_DIGITS digits
//   onto shared active-low cathodes and per-digit active-low anodes. Features:
//   a power-of-two refresh prescaler, PWM brightness, per-digit blinking and
//   per-digit enables.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : synchronous active-high reset
//   digits     : digit k at [6k+5:6k] = {en, hex[3:0], dp}
//   brightness : PWM duty, all-ones = full on, zero = dark
//   blink_mask : bit k set -> digit k blinks
//   AN         : active-low anodes, AN[k] drives digit k
//   sseg       : active-low cathodes {g,f,e,d,c,b,a}
//   DP         : active-low decimal point
//
// Every output is registered. The outputs show the state of the
// previous cycle and the inputs that were live in that cycle.
module sseg_scan_driver #(
  parameter int N_DIGITS      = 8,
  parameter int PRESCALE_BITS = 8,
  parameter int BR_BITS       = 3,
  parameter int BLINK_BITS    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6*N_DIGITS-1:0]   digits,
  input  logic [BR_BITS-1:0]      brightness,
  input  logic [N_DIGITS-1:0]     blink_mask,
  output logic [N_DIGITS-1:0]     AN,
  output logic [6:0]              sseg,
  output logic                    DP
);

  localparam int                IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(N_DIGITS - 1);

  logic [PRESCALE_BITS-1:0] r_pre;
  logic [IDX_W-1:0]         r_idx;
  logic [BLINK_BITS:0]      r_blink;
  logic [N_DIGITS-1:0]      r_an;
  logic [6:0]               r_sseg;
  logic                     r_dp;

  // Unpack the flat digit bus into one 6-bit field per digit.
  logic [5:0] w_dig [N_DIGITS];
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_unpack
    assign w_dig[g] = digits[6*g +: 6];
  end

  logic [5:0]          w_cur;
  logic                w_tick;
  logic                w_pwm_on;
  logic                w_blank;
  logic                w_lit;
  logic [N_DIGITS-1:0] w_onehot;

  assign w_cur    = w_dig[r_idx];
  assign w_tick   = &r_pre;
  // The top BR_BITS of the prescaler form the PWM ramp inside each slot.
  // All-ones brightness is forced on so that full brightness has no gap.
  assign w_pwm_on = (&brightness) |
                    (r_pre[PRESCALE_BITS-1 -: BR_BITS] < brightness);
  assign w_blank  = blink_mask[r_idx] & r_blink[BLINK_BITS];
  assign w_lit    = w_cur[5] & ~w_blank & w_pwm_on;
  assign w_onehot = {{(N_DIGITS-1){1'b0}}, 1'b1} << r_idx;

  function automatic logic [6:0] f_encode(input logic [3:0] h);
    logic [6:0] s;
    s = 7'h7F;
    case (h)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre   <= '0;
      r_idx   <= '0;
      r_blink <= '0;
      r_an    <= '1;
      r_sseg  <= 7'h7F;
      r_dp    <= 1'b1;
    end else begin
      r_pre <= r_pre + 1'b1;
      if (w_tick) begin
        // Explicit wrap keeps idx in range for non-power-of-two digit counts.
        if (r_idx == LAST) begin
          r_idx   <= '0;
          r_blink <= r_blink + 1'b1;
        end else begin
          r_idx   <= r_idx + 1'b1;
        end
      end
      if (w_lit) begin
        r_an   <= ~w_onehot;
        r_sseg <= f_encode(w_cur[4:1]);
        r_dp   <= ~w_cur[0];
      end else begin
        r_an   <= '1;
        r_sseg <= 7'h7F;
        r_dp   <= 1'b1;
      end
    end
  end

  assign AN   = r_an;
  assign sseg = r_sseg;
  assign DP   = r_dp;

endmodule

// File: tb/tb_sseg_scan_driver.sv
module tb_sseg_scan_driver;

  localparam int N  = 4;
  localparam int PB = 3;
  localparam int BR = 2;
  localparam int BB = 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [6*N-1:0]  digits;
  logic [BR-1:0]   brightness;
  logic [N-1:0]    blink_mask;
  logic [N-1:0]    AN;
  logic [6:0]      sseg;
  logic            DP;

  sseg_scan_driver #(.N_DIGITS(N), .PRESCALE_BITS(PB), .BR_BITS(BR), .BLINK_BITS(BB)) dut (
    .clk(clk), .reset(reset), .digits(digits), .brightness(brightness),
    .blink_mask(blink_mask), .AN(AN), .sseg(sseg), .DP(DP)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Digit fields {en, hex, dp}
  localparam logic [5:0] D0 = 6'h22;  // en, 1
  localparam logic [5:0] D1 = 6'h25;  // en, 2, dp
  localparam logic [5:0] D2 = 6'h26;  // en, 3
  localparam logic [5:0] D3 = 6'h28;  // en, 4
  localparam logic [23:0] BASE = {D3, D2, D1, D0};
  localparam logic [23:0] DIS2 = {D3, 6'h06, D1, D0};  // digit 2 disabled
  localparam logic [23:0] HEXA = {D3, D2, D1, 6'h34};  // digit 0 = A
  localparam logic [23:0] HEXF = {D3, D2, D1, 6'h3F};  // digit 0 = F with dp

  logic [6:0] ENC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state and scoreboard queue of {AN, sseg, DP}
  logic [PB-1:0] m_pre;
  int            m_idx;
  logic [BB:0]   m_blk;
  logic [11:0]   sb_q [$];

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got AN=%b sseg=%h DP=%b, want AN=%b sseg=%h DP=%b",
               name, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  // One clock: predict at the rising edge, compare at the falling edge.
  task automatic tick();
    logic [5:0]  dg;
    logic        pwm, blank;
    logic [11:0] e, got;
    @(posedge clk);
    if (reset) begin
      e = {4'hF, 7'h7F, 1'b1};
      m_pre = '0; m_idx = 0; m_blk = '0;
    end else begin
      dg    = digits[6*m_idx +: 6];
      pwm   = (brightness == 2'b11) || (m_pre[PB-1 -: BR] < brightness);
      blank = blink_mask[m_idx] && m_blk[BB];
      if (dg[5] && !blank && pwm) e = {~(4'b0001 << m_idx), ENC[dg[4:1]], ~dg[0]};
      else                        e = {4'hF, 7'h7F, 1'b1};
      if (m_pre == '1) begin
        if (m_idx == N-1) begin m_idx = 0; m_blk = m_blk + 1'b1; end
        else m_idx = m_idx + 1;
      end
      m_pre = m_pre + 1'b1;
    end
    sb_q.push_back(e);
    @(negedge clk);
    got = {AN, sseg, DP};
    chk("scoreboard", got, sb_q.pop_front());
  endtask

  task automatic start(input logic [23:0] d, input logic [1:0] b, input logic [3:0] m);
    digits = d; brightness = b; blink_mask = m;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [23:0] dig;
    logic [1:0]  br;
    logic [3:0]  mask;
    int          t;     // clocks after reset release
    logic [3:0]  an;
    logic [6:0]  ss;
    logic        dp;
  } vec_t;

  vec_t vt [22];

  initial begin
    vt[0]  = '{"first_slot",    BASE, 2'b11, 4'h0,   1, 4'b1110, 7'h79, 1'b1};
    vt[1]  = '{"slot0_end",     BASE, 2'b11, 4'h0,   8, 4'b1110, 7'h79, 1'b1};
    vt[2]  = '{"slot1_dp",      BASE, 2'b11, 4'h0,   9, 4'b1101, 7'h24, 1'b0};
    vt[3]  = '{"slot2",         BASE, 2'b11, 4'h0,  17, 4'b1011, 7'h30, 1'b1};
    vt[4]  = '{"slot3",         BASE, 2'b11, 4'h0,  25, 4'b0111, 7'h19, 1'b1};
    vt[5]  = '{"wrap",          BASE, 2'b11, 4'h0,  33, 4'b1110, 7'h79, 1'b1};
    vt[6]  = '{"disabled",      DIS2, 2'b11, 4'h0,  20, 4'b1111, 7'h7F, 1'b1};
    vt[7]  = '{"dis_other",     DIS2, 2'b11, 4'h0,  12, 4'b1101, 7'h24, 1'b0};
    vt[8]  = '{"pwm1_pre0",     BASE, 2'b01, 4'h0,   1, 4'b1110, 7'h79, 1'b1};
    vt[9]  = '{"pwm1_pre1",     BASE, 2'b01, 4'h0,   2, 4'b1110, 7'h79, 1'b1};
    vt[10] = '{"pwm1_pre2",     BASE, 2'b01, 4'h0,   3, 4'b1111, 7'h7F, 1'b1};
    vt[11] = '{"pwm1_slot1",    BASE, 2'b01, 4'h0,  10, 4'b1101, 7'h24, 1'b0};
    vt[12] = '{"pwm0_dark",     BASE, 2'b00, 4'h0,   1, 4'b1111, 7'h7F, 1'b1};
    vt[13] = '{"pwm2_pre3",     BASE, 2'b10, 4'h0,   4, 4'b1110, 7'h79, 1'b1};
    vt[14] = '{"pwm2_pre4",     BASE, 2'b10, 4'h0,   5, 4'b1111, 7'h7F, 1'b1};
    vt[15] = '{"blink_f0",      BASE, 2'b11, 4'h1,   1, 4'b1110, 7'h79, 1'b1};
    vt[16] = '{"blink_f1",      BASE, 2'b11, 4'h1,  33, 4'b1110, 7'h79, 1'b1};
    vt[17] = '{"blink_f2",      BASE, 2'b11, 4'h1,  65, 4'b1111, 7'h7F, 1'b1};
    vt[18] = '{"blink_f3",      BASE, 2'b11, 4'h1,  97, 4'b1111, 7'h7F, 1'b1};
    vt[19] = '{"blink_f2_d1",   BASE, 2'b11, 4'h1,  73, 4'b1101, 7'h24, 1'b0};
    vt[20] = '{"blink_f4",      BASE, 2'b11, 4'h1, 129, 4'b1110, 7'h79, 1'b1};
    vt[21] = '{"hex_F_dp",      HEXF, 2'b11, 4'h0,   1, 4'b1110, 7'h0E, 1'b0};

    // Reset held three cycles with arbitrary inputs
    digits = 24'hABCDEF; brightness = 2'b11; blink_mask = 4'hF;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_hold", {AN, sseg, DP}, {4'hF, 7'h7F, 1'b1});
    end

    // Table-driven checks
    for (int v = 0; v < 22; v++) begin
      start(vt[v].dig, vt[v].br, vt[v].mask);
      for (int c = 0; c < vt[v].t; c++) tick();
      chk(vt[v].name, {AN, sseg, DP}, {vt[v].an, vt[v].ss, vt[v].dp});
    end

    // Hex A encoding
    start(HEXA, 2'b11, 4'h0);
    tick();
    chk("hex_A", {AN, sseg, DP}, {4'b1110, 7'h08, 1'b1});

    // PWM duty 1: exactly 2 lit cycles per 8-cycle slot
    begin
      int lit;
      start(BASE, 2'b01, 4'h0);
      for (int s = 0; s < 4; s++) begin
        lit = 0;
        for (int c = 0; c < 8; c++) begin
          tick();
          if (AN != 4'hF) lit++;
        end
        chk("pwm1_duty", 12'(lit), 12'd2);
      end
    end

    // Mid-scan reset at idx=2, pre=5
    start(BASE, 2'b11, 4'h0);
    for (int c = 0; c < 21; c++) tick();
    reset = 1'b1;
    tick();
    chk("midscan_reset", {AN, sseg, DP}, {4'hF, 7'h7F, 1'b1});
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("restart_slot0", {AN, sseg, DP}, {4'b1110, 7'h79, 1'b1});
    end
    tick();
    chk("restart_slot1", {AN, sseg, DP}, {4'b1101, 7'h24, 1'b0});

    // Live update of digit 0 mid-slot
    start(BASE, 2'b11, 4'h0);
    for (int c = 0; c < 3; c++) tick();
    chk("live_before", {AN, sseg, DP}, {4'b1110, 7'h79, 1'b1});
    digits = {D3, D2, D1, 6'h30};
    tick();
    chk("live_after", {AN, sseg, DP}, {4'b1110, 7'h00, 1'b1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
